// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meter
//  Purpose  : Gated frequency counter. Counts rising edges of an asynchronous
//             input over back-to-back windows of GATE_CYCLES clock cycles and
//             publishes each window's count with a one-cycle valid strobe.
//             With a 1 s gate (10_000_000 cycles at 10 MHz) the result is Hz.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    GATE_CYCLES : gate window length in clk cycles (>= 4)
//    CNT_W       : width of the edge counter and of meas_freq
//  Ports
//    clk          in   system clock
//    reset_enable in   asynchronous active-high reset
//    enable       in   measurement enable (clk domain)
//    sig_in       in   signal under measurement (asynchronous)
//    meas_freq    out  rising-edge count of the last completed window
//    meas_valid   out  one-cycle strobe marking a new meas_freq
//    meas_ovf     out  edge count saturated in the last completed window
//    busy         out  high while a window is being measured
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 10_000_000,
  parameter int CNT_W       = 24
) (
  input  logic             clk,
  input  logic             reset_enable,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_freq,
  output logic             meas_valid,
  output logic             meas_ovf,
  output logic             busy
);

  localparam int               GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0]   meas_freq_q, meas_freq_d;
  logic               meas_ovf_q, meas_ovf_d;
  logic               meas_valid_q, meas_valid_d;

  logic               sync1_q, sync2_q, sync3_q;

  logic               rise_det;
  logic               terminal;
  logic               sat_hit;
  logic [CNT_W-1:0]   edge_cnt_inc;

  // --------------------------------------------------------------------------
  // Input synchronizer and rising-edge detector. Runs in every state so a
  // level that is already high when a window opens does not look like an edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_enable) begin
    if (reset_enable) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_det = sync2_q & ~sync3_q;
  assign terminal = (gate_cnt_q == GATE_LAST);

  // Saturating increment; sat_hit marks an edge lost because the counter is full
  assign sat_hit      = rise_det && (edge_cnt_q == CNT_MAX);
  assign edge_cnt_inc = (rise_det && !sat_hit) ? edge_cnt_q + 1'b1 : edge_cnt_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_enable) begin
    if (reset_enable) begin
      state_q      <= ST_IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_sticky_q <= 1'b0;
      meas_freq_q  <= '0;
      meas_ovf_q   <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
      meas_freq_q  <= meas_freq_d;
      meas_ovf_q   <= meas_ovf_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    meas_freq_d  = meas_freq_q;
    meas_ovf_d   = meas_ovf_q;
    meas_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gate_cnt_d   = '0;
        edge_cnt_d   = '0;
        ovf_sticky_d = 1'b0;
        if (enable) begin
          state_d = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        // Terminal cycle is tested before enable: a window that reaches its
        // last cycle always publishes, even if enable drops on that cycle.
        if (terminal) begin
          meas_freq_d  = edge_cnt_inc;
          meas_ovf_d   = ovf_sticky_q | sat_hit;
          meas_valid_d = 1'b1;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          ovf_sticky_d = 1'b0;
          state_d      = enable ? ST_MEASURE : ST_IDLE;
        end else if (!enable) begin
          // Abort: partial count is discarded, published result untouched
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          ovf_sticky_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          gate_cnt_d   = gate_cnt_q + 1'b1;
          edge_cnt_d   = edge_cnt_inc;
          ovf_sticky_d = ovf_sticky_q | sat_hit;
        end
      end

      default: begin
        gate_cnt_d   = '0;
        edge_cnt_d   = '0;
        ovf_sticky_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  assign meas_freq  = meas_freq_q;
  assign meas_ovf   = meas_ovf_q;
  assign meas_valid = meas_valid_q;
  assign busy       = (state_q == ST_MEASURE);

endmodule
`default_nettype wire
